// File: rtl/uflash_read_cache_if.sv
// CPU-side request bus of the uflash read cache: sel/wstrb/addr/data_i in, ready/data_o back.
interface uflash_read_cache_if;
  logic        sel;
  logic [3:0]  wstrb;
  logic [14:0] addr;
  logic [31:0] data_i;
  logic        ready;
  logic [31:0] data_o;

  modport master (output sel, wstrb, addr, data_i, input ready, data_o);
  modport slave  (input sel, wstrb, addr, data_i, output ready, data_o);
endinterface

// File: rtl/uflash_read_cache.sv
// Direct-mapped single-word read cache in front of uflash. Hits answer in one cycle,
// everything else is forwarded to flash; erases are held back until the program guard expires.
module uflash_read_cache #(
  parameter int CLK_FREQ  = 5400000,
  parameter int LINE_BITS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  uflash_read_cache_if.slave bus,
  output logic               f_sel,
  output logic [3:0]         f_wstrb,
  output logic [14:0]        f_addr,
  output logic [31:0]        f_data_o,
  input  logic               f_ready,
  input  logic [31:0]        f_data_i
);

  localparam int          LINES      = 1 << LINE_BITS;
  localparam int          TAG_BITS   = 15 - LINE_BITS;
  localparam int          GUARD_INT  = $rtoi(CLK_FREQ * 10.0e-3) + 1;
  localparam logic [23:0] GUARD_CLKS = GUARD_INT[23:0];
  localparam logic [3:0]  WS_READ    = 4'b0000;
  localparam logic [3:0]  WS_PROG    = 4'b1111;
  localparam logic [3:0]  WS_ERASE   = 4'b0001;

  typedef enum logic [1:0] {IDLE, GUARD, FWD, RESP} state_t;

  state_t              state_r, state_nxt;
  logic [LINES-1:0]    valid_r, valid_nxt;
  logic [TAG_BITS-1:0] tag_mem [LINES];
  logic [31:0]         data_mem [LINES];
  logic [23:0]         guard_r, guard_nxt;
  logic                skip_r;
  logic                ready_r, ready_nxt;
  logic [31:0]         data_o_r, data_o_nxt;
  logic                f_sel_r, f_sel_nxt;
  logic [3:0]          f_wstrb_r, f_wstrb_nxt;
  logic [14:0]         f_addr_r, f_addr_nxt;
  logic [31:0]         f_data_r, f_data_nxt;
  logic                fill_s;

  logic [LINE_BITS-1:0] idx_s, f_idx_s;
  logic [TAG_BITS-1:0]  tag_s, f_tag_s;
  logic                 hit_s, f_hit_s, guard_open_s;

  assign idx_s   = bus.addr[LINE_BITS-1:0];
  assign tag_s   = bus.addr[14:LINE_BITS];
  assign hit_s   = valid_r[idx_s] && (tag_mem[idx_s] == tag_s);
  assign f_idx_s = f_addr_r[LINE_BITS-1:0];
  assign f_tag_s = f_addr_r[14:LINE_BITS];
  assign f_hit_s = valid_r[f_idx_s] && (tag_mem[f_idx_s] == f_tag_s);

  // guard_r counts cycles until an erase f_sel may be high; raising f_sel costs one more edge
  assign guard_open_s = (guard_r <= 24'd1);

  assign bus.ready  = ready_r;
  assign bus.data_o = data_o_r;
  assign f_sel      = f_sel_r;
  assign f_wstrb    = f_wstrb_r;
  assign f_addr     = f_addr_r;
  assign f_data_o   = f_data_r;

  // Next-state and next-output logic for the request sequencer.
  always_comb begin
    state_nxt   = state_r;
    ready_nxt   = 1'b0;
    data_o_nxt  = data_o_r;
    f_sel_nxt   = f_sel_r;
    f_wstrb_nxt = f_wstrb_r;
    f_addr_nxt  = f_addr_r;
    f_data_nxt  = f_data_r;
    valid_nxt   = valid_r;
    fill_s      = 1'b0;
    if (guard_r != 24'd0) begin
      guard_nxt = guard_r - 24'd1;
    end else begin
      guard_nxt = 24'd0;
    end
    case (state_r)
      IDLE: begin
        if (bus.sel && !skip_r) begin
          if ((bus.wstrb == WS_READ) && hit_s) begin
            ready_nxt  = 1'b1;
            data_o_nxt = data_mem[idx_s];
            state_nxt  = RESP;
          end else if ((bus.wstrb == WS_ERASE) && !guard_open_s) begin
            state_nxt = GUARD;
          end else begin
            f_sel_nxt   = 1'b1;
            f_wstrb_nxt = bus.wstrb;
            f_addr_nxt  = bus.addr;
            f_data_nxt  = bus.data_i;
            state_nxt   = FWD;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      GUARD: begin
        if (guard_open_s) begin
          f_sel_nxt   = 1'b1;
          f_wstrb_nxt = bus.wstrb;
          f_addr_nxt  = bus.addr;
          f_data_nxt  = bus.data_i;
          state_nxt   = FWD;
        end else begin
          state_nxt = GUARD;
        end
      end
      FWD: begin
        if (f_ready) begin
          f_sel_nxt  = 1'b0;
          ready_nxt  = 1'b1;
          data_o_nxt = f_data_i;
          state_nxt  = RESP;
          case (f_wstrb_r)
            WS_READ: begin
              fill_s             = 1'b1;
              valid_nxt[f_idx_s] = 1'b1;
            end
            WS_PROG: begin
              if (f_hit_s) begin
                valid_nxt[f_idx_s] = 1'b0;
              end else begin
                valid_nxt = valid_r;
              end
              // the completion cycle itself already counts toward the gap
              guard_nxt = GUARD_CLKS - 24'd1;
            end
            WS_ERASE: valid_nxt = {LINES{1'b0}};
            default:  valid_nxt = valid_r;
          endcase
        end else begin
          state_nxt = FWD;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      valid_r   <= {LINES{1'b0}};
      guard_r   <= 24'd0;
      skip_r    <= 1'b0;
      ready_r   <= 1'b0;
      data_o_r  <= 32'd0;
      f_sel_r   <= 1'b0;
      f_wstrb_r <= 4'd0;
      f_addr_r  <= 15'd0;
      f_data_r  <= 32'd0;
    end else begin
      state_r   <= state_nxt;
      valid_r   <= valid_nxt;
      guard_r   <= guard_nxt;
      skip_r    <= (state_r == RESP);
      ready_r   <= ready_nxt;
      data_o_r  <= data_o_nxt;
      f_sel_r   <= f_sel_nxt;
      f_wstrb_r <= f_wstrb_nxt;
      f_addr_r  <= f_addr_nxt;
      f_data_r  <= f_data_nxt;
    end
  end

  // Line tag/data storage; only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_mem[f_idx_s]  <= f_tag_s;
      data_mem[f_idx_s] <= f_data_i;
    end
  end

endmodule

// File: tb/tb_uflash_read_cache.sv
// Bench for uflash_read_cache: directed vector table, random traffic against an address-level
// cache/flash model, program-to-erase guard timing and mid-request reset.
module tb_uflash_read_cache;
  localparam int CLK_FREQ = 1000000;
  localparam int GUARD    = 10001;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        f_sel;
  logic [3:0]  f_wstrb;
  logic [14:0] f_addr;
  logic [31:0] f_data_o;
  logic        f_ready;
  logic [31:0] f_data_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  uflash_read_cache_if bus();

  uflash_read_cache #(.CLK_FREQ(CLK_FREQ), .LINE_BITS(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .f_sel(f_sel), .f_wstrb(f_wstrb), .f_addr(f_addr), .f_data_o(f_data_o),
    .f_ready(f_ready), .f_data_i(f_data_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] flash_mem [int];
  logic [31:0] ref_mem [int];
  int          cached [int];

  function automatic logic [31:0] fdef(input logic [14:0] a);
    return {a, 2'b10, a};
  endfunction

  function automatic logic [31:0] flash_rd(input logic [14:0] a);
    if (flash_mem.exists(int'(a))) return flash_mem[int'(a)];
    return fdef(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [14:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return fdef(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Flash model: answers each request after 0..3 extra cycles with a one-cycle f_ready.
  int fready_cyc = -1;
  bit busy = 1'b0;
  int wait_cnt = 0;
  initial begin
    f_ready  = 1'b0;
    f_data_i = 32'd0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy = 1'b0; f_ready = 1'b0; f_data_i = 32'd0;
      end else if (f_ready) begin
        chk("f_sel_after_f_ready", {31'd0, f_sel}, 32'd0);
        f_ready = 1'b0; f_data_i = 32'd0;
      end else if (f_sel) begin
        if (!busy) begin busy = 1'b1; wait_cnt = $urandom_range(0, 3); end
        if (wait_cnt == 0) begin
          busy = 1'b0; f_ready = 1'b1; fready_cyc = cyc;
          case (f_wstrb)
            4'b1111: begin f_data_i = 32'd0; flash_mem[int'(f_addr)] = f_data_o; end
            4'b0001: begin
              f_data_i = 32'd0;
              for (int c = 0; c < 64; c++) flash_mem[int'({f_addr[14:6], 6'd0}) + c] = 32'hFFFF_FFFF;
            end
            default: f_data_i = flash_rd(f_addr);
          endcase
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  logic [3:0]  cap_wstrb;
  logic [14:0] cap_addr;
  logic [31:0] cap_data;
  int          cap_cyc, start_cyc, rdy_cyc;

  task automatic do_req(input logic [3:0] ws, input logic [14:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output bit fwd);
    bit done;
    done = 1'b0; fwd = 1'b0; rd = 32'd0;
    repeat (2) @(negedge clk);
    bus.sel = 1'b1; bus.wstrb = ws; bus.addr = a; bus.data_i = d;
    start_cyc = cyc;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(negedge clk);
      if (f_sel && !fwd) begin
        fwd = 1'b1; cap_wstrb = f_wstrb; cap_addr = f_addr; cap_data = f_data_o; cap_cyc = cyc;
      end
      if (bus.ready) begin rd = bus.data_o; rdy_cyc = cyc; done = 1'b1; end
    end
    bus.sel = 1'b0; bus.wstrb = 4'd0; bus.addr = 15'd0; bus.data_i = 32'd0;
    if (!done) chk("req_timeout", 32'd0, 32'd1);
  endtask

  // Address-level cache behaviour: which address each line holds, and what flash contains.
  task automatic apply_model(input logic [3:0] ws, input logic [14:0] a, input logic [31:0] d);
    int idx;
    idx = int'(a) % 16;
    if (ws == 4'b0000) begin
      cached[idx] = int'(a);
    end else if (ws == 4'b1111) begin
      if (cached.exists(idx) && cached[idx] == int'(a)) cached.delete(idx);
      ref_mem[int'(a)] = d;
    end else if (ws == 4'b0001) begin
      cached.delete();
      for (int c = 0; c < 64; c++) ref_mem[int'({a[14:6], 6'd0}) + c] = 32'hFFFF_FFFF;
    end
  endtask

  function automatic bit model_hit(input logic [3:0] ws, input logic [14:0] a);
    int idx;
    idx = int'(a) % 16;
    return (ws == 4'b0000) && cached.exists(idx) && (cached[idx] == int'(a));
  endfunction

  task automatic run(input string nm, input logic [3:0] ws, input logic [14:0] a, input logic [31:0] d,
                     input bit exp_fwd, input bit chk_data, input logic [31:0] exp_data);
    logic [31:0] rd;
    bit fwd;
    do_req(ws, a, d, rd, fwd);
    chk({nm, "_fwd"}, {31'd0, fwd}, {31'd0, exp_fwd});
    if (fwd) begin
      chk({nm, "_f_wstrb"}, {28'd0, cap_wstrb}, {28'd0, ws});
      chk({nm, "_f_addr"}, {17'd0, cap_addr}, {17'd0, a});
      chk({nm, "_f_data"}, cap_data, d);
      chk({nm, "_miss_lat"}, 32'(rdy_cyc - fready_cyc), 32'd1);
    end else begin
      chk({nm, "_hit_lat"}, 32'(rdy_cyc - start_cyc), 32'd1);
    end
    if (chk_data) chk({nm, "_data"}, rd, exp_data);
    apply_model(ws, a, d);
  endtask

  typedef struct {
    logic [3:0]  ws;
    logic [14:0] a;
    logic [31:0] d;
    bit          exp_fwd;
    bit          chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int prog_fready;
    logic [3:0]  ws;
    logic [14:0] a;
    logic [31:0] d;
    bit seen;

    vecs[0]  = '{4'b0000, 15'h0005, 32'd0,         1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[1]  = '{4'b0000, 15'h0005, 32'd0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{4'b0000, 15'h0015, 32'd0,         1'b1, 1'b1, fdef(15'h0015)};
    vecs[3]  = '{4'b0000, 15'h0005, 32'd0,         1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[4]  = '{4'b0000, 15'h0005, 32'd0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[5]  = '{4'b1111, 15'h0005, 32'h1234_5678, 1'b1, 1'b0, 32'd0};
    vecs[6]  = '{4'b0000, 15'h0005, 32'd0,         1'b1, 1'b1, 32'h1234_5678};
    vecs[7]  = '{4'b0000, 15'h0023, 32'd0,         1'b1, 1'b1, fdef(15'h0023)};
    vecs[8]  = '{4'b0011, 15'h0040, 32'hAAAA_5555, 1'b1, 1'b1, fdef(15'h0040)};
    vecs[9]  = '{4'b0000, 15'h0005, 32'd0,         1'b0, 1'b1, 32'h1234_5678};
    vecs[10] = '{4'b0000, 15'h0023, 32'd0,         1'b0, 1'b1, fdef(15'h0023)};

    flash_mem[5] = 32'hDEAD_BEEF;
    ref_mem[5]   = 32'hDEAD_BEEF;
    bus.sel = 1'b0; bus.wstrb = 4'd0; bus.addr = 15'd0; bus.data_i = 32'd0;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_data_o", bus.data_o, 32'd0);
    chk("rst_f_sel", {31'd0, f_sel}, 32'd0);
    chk("rst_f_wstrb", {28'd0, f_wstrb}, 32'd0);
    chk("rst_f_addr", {17'd0, f_addr}, 32'd0);
    chk("rst_f_data_o", f_data_o, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++)
      run($sformatf("vec%0d", i), vecs[i].ws, vecs[i].a, vecs[i].d,
          vecs[i].exp_fwd, vecs[i].chk_data, vecs[i].exp_data);

    // Random reads, programs and unsupported strobes over a small address pool.
    for (int i = 0; i < 200; i++) begin
      a = 15'($urandom_range(0, 3) * 16 + $urandom_range(0, 15));
      d = $urandom;
      case ($urandom_range(0, 9))
        0, 1:    ws = 4'b1111;
        2:       ws = 4'($urandom_range(2, 14));
        default: ws = 4'b0000;
      endcase
      run($sformatf("rnd%0d", i), ws, a, d, !model_hit(ws, a), ws != 4'b1111, ref_rd(a));
    end

    // Program-to-erase guard and whole-cache invalidate.
    run("g_fill", 4'b0000, 15'h0023, 32'd0, !model_hit(4'b0000, 15'h0023), 1'b1, ref_rd(15'h0023));
    run("g_hit", 4'b0000, 15'h0023, 32'd0, 1'b0, 1'b1, ref_rd(15'h0023));
    run("g_prog", 4'b1111, 15'h0100, 32'h0BAD_F00D, 1'b1, 1'b0, 32'd0);
    prog_fready = fready_cyc;
    repeat (100) @(negedge clk);
    run("g_erase", 4'b0001, 15'h0100, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("guard_gap", 32'(cap_cyc - prog_fready), 32'(GUARD));
    run("g_after_erase", 4'b0000, 15'h0023, 32'd0, 1'b1, 1'b1, ref_rd(15'h0023));
    run("g_erased_word", 4'b0000, 15'h0100, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    run("g_erase_free", 4'b0001, 15'h0140, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("erase_free_lat", 32'(cap_cyc - start_cyc), 32'd1);

    // Reset while a miss is outstanding.
    run("r_fill", 4'b0000, 15'h0023, 32'd0, 1'b1, 1'b1, ref_rd(15'h0023));
    repeat (2) @(negedge clk);
    bus.sel = 1'b1; bus.wstrb = 4'b0000; bus.addr = 15'h0007; bus.data_i = 32'd0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (f_sel) seen = 1'b1;
    end
    chk("r_fwd_started", {31'd0, seen}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("r_f_sel_drop", {31'd0, f_sel}, 32'd0);
    chk("r_ready_low", {31'd0, bus.ready}, 32'd0);
    bus.sel = 1'b0; bus.addr = 15'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cached.delete();
    run("r_after", 4'b0000, 15'h0023, 32'd0, 1'b1, 1'b1, ref_rd(15'h0023));
    run("r_rehit", 4'b0000, 15'h0023, 32'd0, 1'b0, 1'b1, ref_rd(15'h0023));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
